// File: rtl/lca_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lca_nibble_sequencer
// Description : Multi-nibble adder controller. Adds two NIBBLES x 4-bit
//               operands by time-sharing one external 4-bit lookahead carry
//               adder (no carry-in): pass 1 adds the operand nibbles, pass 2
//               folds in the running carry.
// Revision    : 1.0 - initial release
// ============================================================================
module lca_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic [W-1:0]    ra_q,        ra_d;
    logic [W-1:0]    rb_q,        rb_d;
    logic [IDXW-1:0] idx_q,       idx_d;
    logic            carry_q,     carry_d;
    logic [3:0]      tmp_q,       tmp_d;
    logic            c1_q,        c1_d;
    logic [W-1:0]    work_q,      work_d;
    logic [W-1:0]    result_q,    result_d;
    logic            carry_out_q, carry_out_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;

    logic [3:0]      nib_a;
    logic [3:0]      nib_b;

    // Select the operand nibbles addressed by the current index
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = ra_q[4*i +: 4];
                nib_b = rb_q[4*i +: 4];
            end
        end
    end

    // Adder operands decoded from the registered state only (glitch-free)
    always_comb begin
        add_a = 4'h0;
        add_b = 4'h0;
        case (state_q)
            S_P1: begin
                add_a = nib_a;
                add_b = nib_b;
            end
            S_P2: begin
                add_a = tmp_q;
                add_b = {3'b000, carry_q};
            end
            default: begin
                add_a = 4'h0;
                add_b = 4'h0;
            end
        endcase
    end

    // Next-state and datapath update for the two-pass-per-nibble sequence
    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        tmp_d       = tmp_q;
        c1_d        = c1_q;
        work_d      = work_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = op_a;
                    rb_d    = op_b;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = S_P1;
                end
            end
            S_P1: begin
                tmp_d   = add_sum;
                c1_d    = add_cout;
                state_d = S_P2;
            end
            S_P2: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        work_d[4*i +: 4] = add_sum;
                    end
                end
                // The two passes can never both carry, so OR merges them
                carry_d = c1_q | add_cout;
                if (idx_q == LAST_IDX) begin
                    // Final nibble lands in result on the same edge as DONE entry
                    result_d    = work_d;
                    carry_out_d = carry_d;
                    state_d     = S_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = S_P1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status flags are registered decodes of the next state
        busy_d = (state_d == S_P1) || (state_d == S_P2);
        done_d = (state_d == S_DONE);
    end

    // State registers; active-low synchronous clear aborts any operation
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            ra_q        <= '0;
            rb_q        <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            tmp_q       <= 4'h0;
            c1_q        <= 1'b0;
            work_q      <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            tmp_q       <= tmp_d;
            c1_q        <= c1_d;
            work_q      <= work_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;

endmodule
`default_nettype wire

// File: doc/lca_nibble_sequencer.md
Name: lca_nibble_sequencer

Overview:
- Multi-nibble adder controller. Adds two NIBBLES×4-bit operands by time-sharing one external 4-bit Lookahead_Carry_Adder (ports A, B, Sum, C_out; no carry-in).
- Each nibble takes two adder passes: pass 1 computes a+b, pass 2 adds the running carry.
- Sits between operand source (switches or upstream logic) and the adder instance; result feeds the Display digits.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 1..8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  synchronous, active-low reset (clr=0 resets on the next rising clk edge).
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A; captured on the accepting edge.
- op_b  in  W  operand B; captured on the accepting edge.
- busy  out  1  high in P1/P2.
- done  out  1  single-cycle completion pulse.
- result  out  W  registered sum; updated only on entry to DONE.
- carry_out  out  1  registered final carry; updated with result.
- add_a  out  4  to adder A.
- add_b  out  4  to adder B.
- add_sum  in  4  from adder Sum (combinational).
- add_cout  in  1  from adder C_out (combinational).

Behaviour:
- States: IDLE, P1, P2, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, result=0, carry_out=0, add_a=0, add_b=0. Internal registers cleared: idx, carry, tmp, c1, work.
- Reset wins over everything, including mid-operation: abort, no done pulse, result and carry_out cleared.
- IDLE:
  - add_a=0, add_b=0.
  - If start=1: latch op_a→ra, op_b→rb; set carry=0, idx=0, work=0; go to P1.
- P1:
  - add_a = ra[4*idx+:4], add_b = rb[4*idx+:4].
  - On edge: tmp=add_sum, c1=add_cout; go to P2.
- P2:
  - add_a = tmp, add_b = {3'b000, carry}.
  - On edge: work[4*idx+:4]=add_sum; carry = c1 | add_cout (both can never be 1 together).
  - If idx==NIBBLES-1: go to DONE. Else idx=idx+1 and go to P1.
  - Pass 2 always executes, even when carry=0, so latency is fixed.
- DONE:
  - Entry edge loads result=work and carry_out=carry (final nibble written on the same edge).
  - done=1 for exactly this one cycle; busy=0. Next state is IDLE.
- Latency: start accepted at edge 0 → done high in cycle 2*NIBBLES+1 (cycle 9 for NIBBLES=4). Throughput is one operation per 2*NIBBLES+2 cycles.
- Start handling:
  - start ignored in P1, P2 and DONE; no queuing.
  - start held high continuously re-triggers on each return to IDLE.
- op_a/op_b changes after acceptance do not affect the running operation.
- result/carry_out hold stable from a DONE entry until the next DONE entry.
- add_a/add_b are registered-state decodes, glitch-free relative to state. The adder path is combinational within one cycle (single-cycle path: add_a/add_b → adder → add_sum/add_cout → registers).
- Arithmetic: {carry_out, result} = op_a + op_b, modulo 2^(W+1), no overflow loss.

Test Plan:
- NIBBLES=4, bench instantiates real Lookahead_Carry_Adder.
- start with 0x1234+0x4321 → busy high cycles 1–8, done pulse in cycle 9, result=0x5555, carry_out=0.
- 0xFFFF+0x0001 → carry ripples via every pass 2; result=0x0000, carry_out=1. Also 0xFFFF+0xFFFF → result=0xFFFE, carry_out=1.
- 0x0F0F+0x0101 → result=0x1010, carry_out=0. Check add_b={000,carry} in P2 cycles: 0,1,0,1 across nibbles 0–3.
- Second start pulsed in cycles 3 and 9 (DONE) with different operands → ignored; previous result unchanged; exactly one done pulse. A start in cycle 10 is accepted.
- clr=0 in cycle 5 of an operation → next edge: IDLE, busy=0, result=0, carry_out=0, no done. New start after release gives a correct sum.
- Random 1000 operand pairs against a reference model; start held constantly high → back-to-back ops every 10 cycles, all correct.
